ram_1w_nr_clr: RTL and testbench
================================

Name: ram_1w_nr_clr

Overview:
- Parametrised successor to the team's simple 1-write/1-read RAM primitives.
- One byte-enabled write port, NUM_RD independent read ports and configurable read latency.
- Write-first bypass for same-cycle read/write collisions.
- Hardware clear sequencer: after reset it sweeps every address to INIT_VALUE before accepting traffic.
- Used as the table store for accelerator match/state tables, which must start from a known value after reset.

Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of 8.
- AWIDTH, 9, address width; depth is 2**AWIDTH.
- NUM_RD, 2, number of read ports, 1..4.
- RD_LAT, 2, cycles from rd_en sampled to rd_valid, 2..4.
- INIT_VALUE, 0, DWIDTH-bit value written to every word by the clear sweep.
- CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = skip it, memory content undefined.

Ports:
- clock, input, 1, single clock; all logic on posedge.
- rst, input, 1, asynchronous active-high reset.
- init_done, output, 1, high once the clear sweep has completed.
- wr_ready, output, 1, high when a write is accepted this cycle.
- wr_en, input, 1, write request; accepted only when wr_ready=1.
- wr_addr, input, AWIDTH, write address.
- wr_data, input, DWIDTH, write data.
- wr_be, input, DWIDTH/8, per-byte write enable; bit i covers data[8i+7:8i].
- rd_en, input, NUM_RD, per-port read request.
- rd_addr, input, NUM_RD*AWIDTH, packed read addresses; port p uses [p*AWIDTH +: AWIDTH].
- rd_valid, output, NUM_RD, per-port read data valid.
- rd_data, output, NUM_RD*DWIDTH, packed read data; port p uses [p*DWIDTH +: DWIDTH].

Behaviour:
- Interface: one clock (clock); reset rst is asynchronous and active-high.
- Reset values: init_done=0, wr_ready=0, rd_valid=0, rd_data=0, all pipeline valids 0, FSM=CLEAR, clear counter=0. Memory array is not reset.
- FSM states: CLEAR, RUN.
  - CLEAR: each clock writes INIT_VALUE, all bytes, to clr_addr, then increments clr_addr.
  - CLEAR -> RUN: on the edge that writes address 2**AWIDTH-1. init_done and wr_ready go high on that same edge, i.e. exactly 2**AWIDTH edges after rst deassert.
  - CLEAR_ON_RESET=0: CLEAR -> RUN on the first edge after deassert, with no writes.
  - RUN: terminal until rst.
- Clear-phase gating: while wr_ready=0, wr_en and rd_en are ignored. No rd_valid is produced; wr_en creates no pending write.
- Write pipeline:
  - Stage 1 registers wr_en&wr_ready, address, data and byte enables.
  - Stage 2 commits only the bytes whose wr_be bit is set.
  - The written value is visible in array content one edge after acceptance.
- Read pipeline, per port:
  - Stage 1 registers rd_en and address.
  - Stage 2 reads the array.
  - Stages 3..RD_LAT are plain delay registers.
  - Data and valid emerge RD_LAT edges after sampling; one read per port per cycle, fully pipelined, no backpressure.
  - rd_data holds its last value when rd_valid=0.
- Write-first semantics:
  - A read sampled in cycle t returns contents including every write accepted in cycles <= t.
  - Same-cycle collision (registered addresses equal, registered write valid): the output is a per-byte merge. Enabled bytes come from the write data; the other bytes come from the array.
  - Writes accepted before t are already committed; a single bypass stage suffices.
- Multiple read ports on the same address all return identical data.
- Reset mid-operation:
  - The in-flight write is discarded and in-flight reads are dropped (rd_valid=0 immediately).
  - The FSM restarts CLEAR from address 0.
  - Partial array content from before reset is overwritten by the sweep.
- Elaboration errors: DWIDTH%8!=0, RD_LAT<2 or RD_LAT>4, NUM_RD<1 or NUM_RD>4.

Decomposition:
- Shared package ram_pkg:
  - typedef enum ram_clr_state_t {CLEAR, RUN}.
  - Function be_merge(old, new, be) for byte-merge.
  - Constants RD_LAT_MIN=2 and RD_LAT_MAX=4.
- One natural sub-module, ram_clr_seq:
  - Owns the FSM, clear counter, init_done and wr_ready.
  - Drives the clear-phase write onto the stage-2 write mux.
- Read ports are a generate loop in the top, not separate modules.

Test Plan (AWIDTH=4, DWIDTH=32, NUM_RD=2, RD_LAT=2 unless noted):
1. Clear sweep, INIT_VALUE=32'hDEADBEEF: deassert rst, count edges -> init_done and wr_ready rise on edge 16. Read all 16 addresses on both ports -> 32'hDEADBEEF each, rd_valid exactly 2 edges after rd_en.
2. Byte enables: write addr 3 data 32'h11223344 be=4'hF, then addr 3 data 32'hAABBCCDD be=4'b0101; read addr 3 two cycles later -> 32'h11BB33DD.
3. Collision: addr 5 holds 32'h0. In one cycle write 32'hCAFEF00D be=4'b1100 to addr 5 and read addr 5 on port 0 -> port 0 returns 32'hCAFE0000. Port 1 reading addr 6 in the same cycle -> unaffected INIT_VALUE.
4. Latency sweep RD_LAT=3 and 4: back-to-back reads of addrs 0..15 every cycle -> 16 consecutive rd_valid pulses, data in order, first valid 3 (resp. 4) edges after first rd_en.
5. Clear-phase gating: assert wr_en (addr 2, 32'h5) and rd_en during CLEAR -> no rd_valid pulse. After init_done, addr 2 reads INIT_VALUE.
6. Reset mid-operation: assert rst at random cycles in RUN with reads in flight -> rd_valid drops the same cycle, init_done=0. Re-clear completes 16 edges after deassert and all words read INIT_VALUE. Repeat with CLEAR_ON_RESET=0 -> init_done=1 on the first edge after deassert.

Source files
------------

// File: rtl/ram_1w_nr_clr_pkg.sv
// Shared types and helpers for the cleared multi-read-port RAM.
// Holds the clear FSM state type, read-latency limits and the byte-lane merge used by the write bypass.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_clr_state_t;

  localparam int RD_LAT_MIN = 2;
  localparam int RD_LAT_MAX = 4;
  localparam int NUM_RD_MIN = 1;
  localparam int NUM_RD_MAX = 4;

  // One byte lane of a write-enable merge: the enabled lane takes the new byte.
  function automatic logic [7:0] be_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_1w_nr_clr_clr_seq.sv
// Clear sequencer: sweeps every address once after reset, then opens the RAM to traffic.
// init_done and wr_ready share one register so they rise on the same edge.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int AWIDTH         = 9,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_rst,
  output logic              o_init_done,
  output logic              o_wr_ready,
  output logic              o_clr_we,
  output logic [AWIDTH-1:0] o_clr_addr
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};
  localparam logic [AWIDTH-1:0] ADDR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};

  ram_clr_state_t    r_state;
  logic [AWIDTH-1:0] r_clr_addr;
  logic              r_init_done;

  // Sweep addresses 0..2**AWIDTH-1; the edge writing the last one also enters RUN.
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= CLEAR;
      r_clr_addr  <= {AWIDTH{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (!CLEAR_ON_RESET || (r_clr_addr == LAST_ADDR)) begin
            r_state     <= RUN;
            r_clr_addr  <= {AWIDTH{1'b0}};
            r_init_done <= 1'b1;
          end else begin
            r_clr_addr  <= r_clr_addr + ADDR_ONE;
          end
        end
        RUN: begin
          r_state     <= RUN;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= CLEAR;
          r_clr_addr  <= {AWIDTH{1'b0}};
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_init_done = r_init_done;
  assign o_wr_ready  = r_init_done;
  assign o_clr_we    = (r_state == CLEAR) && CLEAR_ON_RESET;
  assign o_clr_addr  = r_clr_addr;

endmodule

// File: rtl/ram_1w_nr_clr.sv
// Byte-enabled 1-write / NUM_RD-read RAM with write-first bypass and a post-reset clear sweep.
// Reads return data RD_LAT edges after sampling, counting the sampling edge.
module ram_1w_nr_clr
  import ram_pkg::*;
#(
  parameter int                 DWIDTH         = 32,
  parameter int                 AWIDTH         = 9,
  parameter int                 NUM_RD         = 2,
  parameter int                 RD_LAT         = 2,
  parameter logic [DWIDTH-1:0]  INIT_VALUE     = {DWIDTH{1'b0}},
  parameter bit                 CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clock,
  input  logic                     rst,
  output logic                     init_done,
  output logic                     wr_ready,
  input  logic                     wr_en,
  input  logic [AWIDTH-1:0]        wr_addr,
  input  logic [DWIDTH-1:0]        wr_data,
  input  logic [DWIDTH/8-1:0]      wr_be,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AWIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*DWIDTH-1:0] rd_data
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NSTG   = RD_LAT - 1;

  if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
    $error("ram_1w_nr_clr: DWIDTH must be a multiple of 8");
  end
  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("ram_1w_nr_clr: RD_LAT must be in 2..4");
  end
  if ((NUM_RD < NUM_RD_MIN) || (NUM_RD > NUM_RD_MAX)) begin : g_bad_num_rd
    $error("ram_1w_nr_clr: NUM_RD must be in 1..4");
  end

  logic              w_wr_ready;
  logic              w_clr_we;
  logic [AWIDTH-1:0] w_clr_addr;

  ram_clr_seq #(
    .AWIDTH         (AWIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr_seq (
    .i_clock     (clock),
    .i_rst       (rst),
    .o_init_done (init_done),
    .o_wr_ready  (w_wr_ready),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr)
  );

  assign wr_ready = w_wr_ready;

  logic              r_wr_v;
  logic [AWIDTH-1:0] r_wr_addr;
  logic [DWIDTH-1:0] r_wr_data;
  logic [NBYTES-1:0] r_wr_be;

  // Write stage 1: capture accepted requests; reset discards an in-flight write.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr_v    <= 1'b0;
      r_wr_addr <= {AWIDTH{1'b0}};
      r_wr_data <= {DWIDTH{1'b0}};
      r_wr_be   <= {NBYTES{1'b0}};
    end else begin
      r_wr_v    <= wr_en & w_wr_ready;
      r_wr_addr <= wr_addr;
      r_wr_data <= wr_data;
      r_wr_be   <= wr_be;
    end
  end

  logic              w_mem_we;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [DWIDTH-1:0] w_mem_wdata;
  logic [NBYTES-1:0] w_mem_be;

  // Write stage 2 mux: the clear sweep owns the port until traffic is allowed.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_wr_addr;
    w_mem_wdata = r_wr_data;
    w_mem_be    = r_wr_be;
    if (w_clr_we) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = w_clr_addr;
      w_mem_wdata = INIT_VALUE;
      w_mem_be    = {NBYTES{1'b1}};
    end else begin
      w_mem_we    = r_wr_v;
    end
  end

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // Storage array, byte-lane writes, deliberately not reset.
  always_ff @(posedge clock) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (w_mem_we && w_mem_be[b]) begin
        r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic              r_rd_v;
    logic [AWIDTH-1:0] r_rd_addr;
    logic [DWIDTH-1:0] w_arr;
    logic [DWIDTH-1:0] w_byp;
    logic              w_hit;
    logic [NSTG-1:0]   r_pv;
    logic [DWIDTH-1:0] r_pd [NSTG];

    // Read stage 1: sample request and address.
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        r_rd_v    <= 1'b0;
        r_rd_addr <= {AWIDTH{1'b0}};
      end else begin
        r_rd_v    <= rd_en[p] & w_wr_ready;
        r_rd_addr <= rd_addr[p*AWIDTH +: AWIDTH];
      end
    end

    // A write sampled on the same edge has not committed yet, so merge it in here.
    assign w_arr = r_mem[r_rd_addr];
    assign w_hit = r_wr_v && (r_wr_addr == r_rd_addr);

    for (genvar b = 0; b < NBYTES; b++) begin : g_byp
      assign w_byp[8*b +: 8] = be_merge(w_arr[8*b +: 8], r_wr_data[8*b +: 8],
                                        w_hit & r_wr_be[b]);
    end

    // Read stage 2 and delay stages; data registers only move with a valid beat.
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        r_pv <= {NSTG{1'b0}};
        for (int s = 0; s < NSTG; s++) begin
          r_pd[s] <= {DWIDTH{1'b0}};
        end
      end else begin
        r_pv[0] <= r_rd_v;
        if (r_rd_v) begin
          r_pd[0] <= w_byp;
        end
        for (int s = 1; s < NSTG; s++) begin
          r_pv[s] <= r_pv[s-1];
          if (r_pv[s-1]) begin
            r_pd[s] <= r_pd[s-1];
          end
        end
      end
    end

    assign rd_valid[p]                 = r_pv[NSTG-1];
    assign rd_data[p*DWIDTH +: DWIDTH] = r_pd[NSTG-1];
  end

endmodule

// File: tb/tb_ram_1w_nr_clr.sv
// Bench for ram_1w_nr_clr: three cleared instances (RD_LAT 2/3/4) and one without clear share one stimulus.
// Expected data comes from a word-array model where a read sees every write sampled on or before its edge.
module tb_ram_1w_nr_clr;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INIT  = 32'hDEADBEEF;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0] wr_be;
  logic [1:0] rd_en;
  logic [7:0] rd_addr;

  logic [2:0]       idn;
  logic [2:0]       wrdy;
  logic [2:0][1:0]  rv;
  logic [2:0][63:0] rdd;
  logic             dn_init, dn_wrdy;
  logic [1:0]       dn_rv;
  logic [63:0]      dn_rd;

  always #5 clock = ~clock;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    ram_1w_nr_clr #(
      .DWIDTH(32), .AWIDTH(AW), .NUM_RD(2), .RD_LAT(2 + i),
      .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)
    ) u_dut (
      .clock(clock), .rst(rst), .init_done(idn[i]), .wr_ready(wrdy[i]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[i]), .rd_data(rdd[i])
    );
  end

  ram_1w_nr_clr #(
    .DWIDTH(32), .AWIDTH(AW), .NUM_RD(2), .RD_LAT(2),
    .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b0)
  ) u_dut_noclr (
    .clock(clock), .rst(rst), .init_done(dn_init), .wr_ready(dn_wrdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(dn_rv), .rd_data(dn_rd)
  );

  logic [31:0]      mem [DEPTH];
  logic [1:0]       sv [int];
  logic [63:0]      sd [int];
  logic [2:0][1:0]  ev;
  logic [2:0][63:0] ed;
  int cyc = 0;
  int since = 0;
  bit exp_ready = 1'b0;
  int nchk = 0;
  int npass = 0;

  task automatic reset_model();
    sv.delete();
    sd.delete();
    ev = '0;
    ed = '0;
    since = 0;
    exp_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = INIT;
  endtask

  // Applies the current inputs to the model, advances one edge, derives expected outputs.
  task automatic tick();
    int n;
    logic [1:0]  s_v;
    logic [63:0] s_d;
    n = cyc + 1;
    s_v = 2'b00;
    s_d = 64'h0;
    if (!rst && exp_ready) begin
      if (wr_en)
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      for (int p = 0; p < 2; p++)
        if (rd_en[p]) begin
          s_v[p] = 1'b1;
          s_d[32*p +: 32] = mem[rd_addr[4*p +: 4]];
        end
    end
    sv[n] = s_v;
    sd[n] = s_d;
    @(posedge clock);
    cyc = n;
    if (!rst) since++;
    exp_ready = (since >= DEPTH);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = cyc - (2 + i) + 1;
      ev[i] = sv.exists(k) ? sv[k] : 2'b00;
      for (int p = 0; p < 2; p++)
        if (ev[i][p]) ed[i][32*p +: 32] = sd[k][32*p +: 32];
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0; wr_be = 4'h0;
    rd_en = 2'b00; rd_addr = 8'h00;
  endtask

  task automatic rand_stim();
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = 4'($urandom_range(0, 15));
    wr_data = 32'($urandom);
    wr_be   = 4'($urandom_range(0, 15));
    rd_en   = 2'($urandom_range(0, 3));
    for (int p = 0; p < 2; p++)
      rd_addr[4*p +: 4] = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_model();
    tick();
    tick();
    nchk++; if (idn !== 3'b000 || dn_init !== 1'b0) $display("FAIL reset_init_done: got %b/%b want 000/0", idn, dn_init); else npass++;
    nchk++; if (wrdy !== 3'b000 || dn_wrdy !== 1'b0) $display("FAIL reset_wr_ready: got %b/%b want 000/0", wrdy, dn_wrdy); else npass++;
    nchk++; if (rv !== 6'b0 || dn_rv !== 2'b00) $display("FAIL reset_rd_valid: got %b/%b want 0", rv, dn_rv); else npass++;
    nchk++; if (rdd !== 192'h0 || dn_rd !== 64'h0) $display("FAIL reset_rd_data: got %h want 0", rdd[0]); else npass++;
  endtask

  task automatic test_clear_gating();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h5; wr_be = 4'hF;
    rd_en = 2'b11; rd_addr = {4'd2, 4'd2};
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      nchk++; if (idn !== {3{e == DEPTH}}) $display("FAIL clear_init_done edge%0d: got %b want %b", e, idn, {3{e == DEPTH}}); else npass++;
      nchk++; if (wrdy !== {3{e == DEPTH}}) $display("FAIL clear_wr_ready edge%0d: got %b want %b", e, wrdy, {3{e == DEPTH}}); else npass++;
      nchk++; if (rv !== 6'b0) $display("FAIL clear_no_rd_valid edge%0d: got %b want 0", e, rv); else npass++;
      if (e == 1) begin
        nchk++; if (dn_init !== 1'b1) $display("FAIL noclr_init_done: got %b want 1", dn_init); else npass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_read_all();
    int pulses [3];
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    for (int t = 0; t < DEPTH + 4; t++) begin
      if (t < DEPTH) begin
        rd_en = 2'b11;
        rd_addr = {4'(15 - t), 4'(t)};
      end else begin
        rd_en = 2'b00;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        nchk++; if (rv[i] !== ev[i]) $display("FAIL readall_valid lat%0d cyc%0d: got %b want %b", 2 + i, cyc, rv[i], ev[i]); else npass++;
        nchk++; if (rdd[i] !== ed[i]) $display("FAIL readall_data lat%0d cyc%0d: got %h want %h", 2 + i, cyc, rdd[i], ed[i]); else npass++;
        if (rv[i][0]) pulses[i]++;
      end
      if (rv[0] != 2'b00) begin
        nchk++; if (rdd[0] !== {INIT, INIT}) $display("FAIL readall_init cyc%0d: got %h want %h", cyc, rdd[0], {INIT, INIT}); else npass++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      nchk++; if (pulses[i] !== 16) $display("FAIL readall_pulses lat%0d: got %0d want 16", 2 + i, pulses[i]); else npass++;
    end
  endtask

  task automatic test_byte_enable();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h11223344; wr_be = 4'hF;
    tick();
    wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    tick();
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
    for (int t = 0; t < 4; t++) begin
      tick();
      rd_en = 2'b00;
      if (t == 1) begin
        nchk++; if (rv[0][0] !== 1'b1 || rdd[0][31:0] !== 32'h11BB33DD) $display("FAIL byte_enable: got v=%b %h want v=1 11bb33dd", rv[0][0], rdd[0][31:0]); else npass++;
      end
      for (int i = 0; i < 3; i++) begin
        nchk++; if (rv[i] !== ev[i] || rdd[i] !== ed[i]) $display("FAIL byte_enable_model lat%0d cyc%0d: got %b %h want %b %h", 2 + i, cyc, rv[i], rdd[i], ev[i], ed[i]); else npass++;
      end
    end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0; wr_be = 4'hF;
    tick();
    wr_data = 32'hCAFEF00D; wr_be = 4'b1100;
    rd_en = 2'b11; rd_addr = {4'd6, 4'd5};
    tick();
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
    for (int t = 0; t < 5; t++) begin
      tick();
      rd_en = 2'b00;
      if (t == 0) begin
        nchk++; if (rv[0] !== 2'b11 || rdd[0] !== {INIT, 32'hCAFE0000}) $display("FAIL collision_same_cycle: got %b %h want 11 %h", rv[0], rdd[0], {INIT, 32'hCAFE0000}); else npass++;
      end
      if (t == 1) begin
        nchk++; if (rv[0] !== 2'b01 || rdd[0] !== {INIT, 32'hCAFE0000}) $display("FAIL collision_next_cycle: got %b %h want 01 %h", rv[0], rdd[0], {INIT, 32'hCAFE0000}); else npass++;
      end
      for (int i = 0; i < 3; i++) begin
        nchk++; if (rv[i] !== ev[i] || rdd[i] !== ed[i]) $display("FAIL collision_model lat%0d cyc%0d: got %b %h want %b %h", 2 + i, cyc, rv[i], rdd[i], ev[i], ed[i]); else npass++;
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      rand_stim();
      tick();
      for (int i = 0; i < 3; i++) begin
        nchk++; if (rv[i] !== ev[i]) $display("FAIL random_valid lat%0d cyc%0d: got %b want %b", 2 + i, cyc, rv[i], ev[i]); else npass++;
        nchk++; if (rdd[i] !== ed[i]) $display("FAIL random_data lat%0d cyc%0d: got %h want %h", 2 + i, cyc, rdd[i], ed[i]); else npass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 3; r++) begin
      int run;
      run = $urandom_range(5, 30);
      for (int t = 0; t < run; t++) begin
        rand_stim();
        rd_en = 2'b11;
        tick();
        for (int i = 0; i < 3; i++) begin
          nchk++; if (rv[i] !== ev[i] || rdd[i] !== ed[i]) $display("FAIL midrst_run lat%0d cyc%0d: got %b %h want %b %h", 2 + i, cyc, rv[i], rdd[i], ev[i], ed[i]); else npass++;
        end
      end
      rst = 1'b1;
      #1;
      reset_model();
      nchk++; if (rv !== 6'b0 || dn_rv !== 2'b00) $display("FAIL midrst_valid_drop: got %b/%b want 0", rv, dn_rv); else npass++;
      nchk++; if (idn !== 3'b000 || dn_init !== 1'b0 || wrdy !== 3'b000) $display("FAIL midrst_init_done: got %b/%b/%b want 0", idn, dn_init, wrdy); else npass++;
      nchk++; if (rdd !== 192'h0) $display("FAIL midrst_rd_data: got %h want 0", rdd[0]); else npass++;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      for (int e = 1; e <= DEPTH; e++) begin
        tick();
        nchk++; if (idn !== {3{e == DEPTH}}) $display("FAIL midrst_reclear edge%0d: got %b want %b", e, idn, {3{e == DEPTH}}); else npass++;
        if (e == 1) begin
          nchk++; if (dn_init !== 1'b1) $display("FAIL midrst_noclr_init: got %b want 1", dn_init); else npass++;
        end
      end
      for (int t = 0; t < DEPTH + 4; t++) begin
        rd_en = (t < DEPTH) ? 2'b11 : 2'b00;
        rd_addr = {4'(t), 4'(15 - t)};
        tick();
        for (int i = 0; i < 3; i++) begin
          nchk++; if (rv[i] !== ev[i] || rdd[i] !== ed[i]) $display("FAIL midrst_readback lat%0d cyc%0d: got %b %h want %b %h", 2 + i, cyc, rv[i], rdd[i], ev[i], ed[i]); else npass++;
        end
        if (rv[2] != 2'b00) begin
          nchk++; if (rdd[2] !== {INIT, INIT}) $display("FAIL midrst_init_value cyc%0d: got %h want %h", cyc, rdd[2], {INIT, INIT}); else npass++;
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_clear_gating();
    test_read_all();
    test_byte_enable();
    test_collision();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
